// File: rtl/msync_trigger_cond.sv
// DAQ start/stop sync front end: synchronize, filter and edge-detect
// the external sync lines, then sequence them into active-low strobes.
module msync_trigger_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int HOLDOFF_W   = 16,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ext_start_n,
    input  logic                 ext_stop_n,
    input  logic                 arm,
    input  logic                 sw_start,
    input  logic                 sw_stop,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic                 nstart_daq,
    output logic                 nstop_daq,
    output logic                 running,
    output logic [CNT_W-1:0]     start_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam logic [FW-1:0] FLEN = FW'(FILT_LEN);

    typedef enum logic [1:0] {
        DISARMED,
        ARMED,
        RUNNING,
        HOLDOFF
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] start_sync;
    logic [SYNC_STAGES-1:0] stop_sync;
    logic [1:0]             raw;
    logic [1:0]             filt;
    logic [1:0]             filt_q;
    logic [FW-1:0]          fcnt [2];
    logic [1:0]             hw_ev;
    logic [HOLDOFF_W-1:0]   hcnt;

    logic start_ev;
    logic stop_ev;
    logic accept_start;
    logic drop;

    // Metastability chains; idle level of the lines is high
    always_ff @(posedge clk) begin
        if (reset) begin
            start_sync <= '1;
            stop_sync  <= '1;
        end else begin
            start_sync <= {start_sync[SYNC_STAGES-2:0], ext_start_n};
            stop_sync  <= {stop_sync[SYNC_STAGES-2:0], ext_stop_n};
        end
    end

    assign raw = {stop_sync[SYNC_STAGES-1], start_sync[SYNC_STAGES-1]};

    // Glitch filter: a level must differ for FILT_LEN cycles before it is taken
    always_ff @(posedge clk) begin
        if (reset) begin
            filt    <= '1;
            filt_q  <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (fcnt[i] == FLEN) begin
                    filt[i] <= ~filt[i];
                    fcnt[i] <= '0;
                end else if (raw[i] != filt[i]) begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    // Only falling edges of the filtered lines are events
    assign hw_ev    = filt_q & ~filt;
    assign start_ev = hw_ev[0] | sw_start;
    assign stop_ev  = hw_ev[1] | sw_stop;

    // Accepted start and "event ignored" decisions; arm=0 silences both
    always_comb begin
        accept_start = 1'b0;
        drop         = 1'b0;
        if (arm) begin
            unique case (state)
                ARMED: begin
                    accept_start = start_ev;
                    drop         = stop_ev;
                end
                RUNNING: drop = start_ev;
                HOLDOFF: drop = start_ev | stop_ev;
                default: drop = 1'b0;
            endcase
        end
    end

    // Sequencer with registered strobes; every strobe lasts one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DISARMED;
            hcnt       <= '0;
            nstart_daq <= 1'b1;
            nstop_daq  <= 1'b1;
        end else begin
            nstart_daq <= 1'b1;
            nstop_daq  <= 1'b1;
            unique case (state)
                DISARMED: begin
                    if (arm) state <= ARMED;
                end
                ARMED: begin
                    if (!arm) begin
                        state <= DISARMED;
                    end else if (start_ev) begin
                        nstart_daq <= 1'b0;
                        state      <= RUNNING;
                    end
                end
                RUNNING: begin
                    if (!arm) begin
                        nstop_daq <= 1'b0;
                        state     <= DISARMED;
                    end else if (stop_ev) begin
                        nstop_daq <= 1'b0;
                        hcnt      <= holdoff - 1'b1;
                        state     <= (holdoff == '0) ? ARMED : HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (!arm) begin
                        state <= DISARMED;
                    end else if (hcnt == '0) begin
                        state <= ARMED;
                    end else begin
                        hcnt <= hcnt - 1'b1;
                    end
                end
                default: state <= DISARMED;
            endcase
        end
    end

    assign running = (state == RUNNING);

    // Status counters: starts wrap, drops saturate
    always_ff @(posedge clk) begin
        if (reset) begin
            start_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (accept_start) start_cnt <= start_cnt + 1'b1;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_msync_trigger_cond.sv
// Directed bench for msync_trigger_cond with default parameters.
module tb_msync_trigger_cond;

    logic        clk = 1'b0;
    logic        reset;
    logic        ext_start_n;
    logic        ext_stop_n;
    logic        arm;
    logic        sw_start;
    logic        sw_stop;
    logic [15:0] holdoff;
    logic        nstart_daq;
    logic        nstop_daq;
    logic        running;
    logic [15:0] start_cnt;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    msync_trigger_cond dut (
        .clk(clk),
        .reset(reset),
        .ext_start_n(ext_start_n),
        .ext_stop_n(ext_stop_n),
        .arm(arm),
        .sw_start(sw_start),
        .sw_stop(sw_stop),
        .holdoff(holdoff),
        .nstart_daq(nstart_daq),
        .nstop_daq(nstop_daq),
        .running(running),
        .start_cnt(start_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int first;
    int lows;
    int stops;

    initial begin
        reset       = 1'b1;
        ext_start_n = 1'b1;
        ext_stop_n  = 1'b1;
        arm         = 1'b0;
        sw_start    = 1'b0;
        sw_stop     = 1'b0;
        holdoff     = 16'd0;
        repeat (3) step();
        check("rst_nstart", nstart_daq, 1);
        check("rst_nstop", nstop_daq, 1);
        check("rst_running", running, 0);
        check("rst_start_cnt", start_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        reset = 1'b0;
        arm   = 1'b1;
        step();

        // glitch shorter than the filter: no strobe
        ext_start_n = 1'b0;
        repeat (3) step();
        ext_start_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!nstart_daq) lows++;
        end
        check("glitch_strobes", lows, 0);
        check("glitch_start_cnt", start_cnt, 0);
        check("glitch_running", running, 0);

        // long low on ext_start_n: strobe 7 edges after first sample
        ext_start_n = 1'b0;
        first = -1;
        lows  = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (!nstart_daq) begin
                lows++;
                if (first < 0) first = i;
            end
            if (i == 9) ext_start_n = 1'b1;
        end
        check("ext_start_lows", lows, 1);
        check("ext_start_latency", first, 7);
        check("ext_start_running", running, 1);
        check("ext_start_cnt", start_cnt, 1);
        repeat (8) step();

        // stop with holdoff 5, events during holdoff dropped
        holdoff = 16'd5;
        sw_stop = 1'b1;
        step();
        sw_stop = 1'b0;
        check("ho_nstop", nstop_daq, 0);
        check("ho_running", running, 0);
        step();
        check("ho_nstop_one", nstop_daq, 1);
        sw_start = 1'b1;
        step();
        sw_start = 1'b0;
        check("ho_drop1_nstart", nstart_daq, 1);
        check("ho_drop1_cnt", drop_cnt, 1);
        repeat (2) step();
        sw_start = 1'b1;
        step();
        check("ho_edge_nstart", nstart_daq, 1);
        check("ho_edge_drop", drop_cnt, 2);
        step();
        sw_start = 1'b0;
        check("ho_rearm_nstart", nstart_daq, 0);
        check("ho_rearm_cnt", start_cnt, 2);
        check("ho_rearm_running", running, 1);

        // holdoff 0 returns straight to ARMED; simultaneous requests
        holdoff = 16'd0;
        sw_stop = 1'b1;
        step();
        sw_stop = 1'b0;
        check("h0_nstop", nstop_daq, 0);
        sw_start = 1'b1;
        sw_stop  = 1'b1;
        step();
        check("both_armed_nstart", nstart_daq, 0);
        check("both_armed_nstop", nstop_daq, 1);
        check("both_armed_running", running, 1);
        check("both_armed_drop", drop_cnt, 3);
        check("both_armed_cnt", start_cnt, 3);
        step();
        sw_start = 1'b0;
        sw_stop  = 1'b0;
        check("both_run_nstart", nstart_daq, 1);
        check("both_run_nstop", nstop_daq, 0);
        check("both_run_running", running, 0);
        check("both_run_drop", drop_cnt, 4);

        // disarm while running gives exactly one stop strobe
        sw_start = 1'b1;
        step();
        sw_start = 1'b0;
        check("d_running", running, 1);
        check("d_cnt", start_cnt, 4);
        arm = 1'b0;
        stops = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!nstop_daq) stops++;
        end
        check("disarm_nstop_pulses", stops, 1);
        check("disarm_running", running, 0);
        ext_start_n = 1'b0;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!nstart_daq) lows++;
            if (i == 9) ext_start_n = 1'b1;
        end
        check("disarm_ext_strobes", lows, 0);
        check("disarm_drop", drop_cnt, 4);
        check("disarm_cnt", start_cnt, 4);

        // reset while running clears everything silently
        arm = 1'b1;
        step();
        sw_start = 1'b1;
        step();
        sw_start = 1'b0;
        check("pre_rst_running", running, 1);
        reset = 1'b1;
        lows  = 0;
        stops = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (!nstart_daq) lows++;
            if (!nstop_daq) stops++;
        end
        check("mid_rst_running", running, 0);
        check("mid_rst_start_cnt", start_cnt, 0);
        check("mid_rst_drop_cnt", drop_cnt, 0);
        reset    = 1'b0;
        sw_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            sw_start = 1'b0;
            if (!nstart_daq) lows++;
            if (!nstop_daq) stops++;
        end
        check("post_rst_nstart_lows", lows, 0);
        check("post_rst_nstop_lows", stops, 0);
        check("post_rst_start_cnt", start_cnt, 0);
        check("post_rst_drop_cnt", drop_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
